// File: rtl/truncador_saturado_pwm_if.sv
// Sample path from the filter into the PWM truncator: signed sample plus its one-cycle valid strobe.
// The filter side drives the bus and the truncator side receives it.
interface truncador_saturado_pwm_if #(
    parameter int CANT_BITS = 13
);
    logic signed [CANT_BITS-1:0] dato_infiltro;
    logic                        dato_valid;

    modport master (
        output dato_infiltro,
        output dato_valid
    );

    modport slave (
        input  dato_infiltro,
        input  dato_valid
    );
endinterface

// File: rtl/truncador_saturado_pwm.sv
// Scales, saturates and offsets filter samples into a double-buffered duty value,
// then drives a counter-based PWM whose duty only changes at period boundaries.
module truncador_saturado_pwm #(
    parameter int CANT_BITS = 13,
    parameter int BITS_PWM  = 8,
    parameter int DESPL     = 2,
    parameter int REDONDEO  = 0,
    parameter int DIV       = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    truncador_saturado_pwm_if.slave        entrada,
    output logic                           pwm_out,
    output logic                           fin_periodo,
    output logic                           sat_alto,
    output logic                           sat_bajo,
    output logic                           muestra_perdida
);
    localparam int W      = CANT_BITS + 1;
    localparam int PW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SH_RND = (DESPL > 0) ? DESPL - 1 : 0;

    localparam logic signed [W-1:0] V_MAX = W'((1 << (BITS_PWM - 1)) - 1);
    localparam logic signed [W-1:0] V_MIN = W'(-(1 << (BITS_PWM - 1)));
    localparam logic signed [W-1:0] V_RND = (REDONDEO != 0 && DESPL > 0) ? W'(1 << SH_RND) : {W{1'b0}};

    localparam logic [PW-1:0]       PRESC_FIN   = PW'(DIV - 1);
    localparam logic [BITS_PWM-1:0] CONT_FIN    = {BITS_PWM{1'b1}};
    localparam logic [BITS_PWM-1:0] DUTY_NEUTRO = {1'b1, {(BITS_PWM-1){1'b0}}};

    logic signed [W-1:0]   suma_s;
    logic signed [W-1:0]   escala_s;
    logic [BITS_PWM-1:0]   recorte_s;
    logic [BITS_PWM-1:0]   duty_s;
    logic                  alto_s;
    logic                  bajo_s;

    // run_r holds the counters still for the first edge after reset so the period starts cleanly at count 0
    logic                  run_r;
    logic [PW-1:0]         presc_r;
    logic [BITS_PWM-1:0]   contador_r;
    logic [BITS_PWM-1:0]   duty_activo_r;
    logic [BITS_PWM-1:0]   muestra_pend_r;
    logic                  pendiente_r;

    logic                  tick_s;
    logic                  fin_s;
    logic [PW-1:0]         presc_nx_s;
    logic [BITS_PWM-1:0]   contador_nx_s;
    logic [BITS_PWM-1:0]   duty_nx_s;
    logic                  pwm_nx_s;
    logic                  fin_nx_s;

    // Sample scaling, clipping into the PWM range and conversion to offset binary
    always_comb begin
        suma_s    = $signed({entrada.dato_infiltro[CANT_BITS-1], entrada.dato_infiltro}) + V_RND;
        escala_s  = suma_s >>> DESPL;
        alto_s    = 1'b0;
        bajo_s    = 1'b0;
        recorte_s = escala_s[BITS_PWM-1:0];
        if (escala_s > V_MAX) begin
            alto_s    = 1'b1;
            recorte_s = V_MAX[BITS_PWM-1:0];
        end else if (escala_s < V_MIN) begin
            bajo_s    = 1'b1;
            recorte_s = V_MIN[BITS_PWM-1:0];
        end else begin
            recorte_s = escala_s[BITS_PWM-1:0];
        end
        duty_s = {~recorte_s[BITS_PWM-1], recorte_s[BITS_PWM-2:0]};
    end

    // Next-state of prescaler, counter and active duty; outputs are registered from these look-ahead values
    always_comb begin
        tick_s        = run_r && (presc_r == PRESC_FIN);
        fin_s         = tick_s && (contador_r == CONT_FIN);
        presc_nx_s    = presc_r;
        contador_nx_s = contador_r;
        if (!run_r) begin
            presc_nx_s    = {PW{1'b0}};
            contador_nx_s = contador_r;
        end else if (tick_s) begin
            presc_nx_s    = {PW{1'b0}};
            contador_nx_s = contador_r + 1'b1;
        end else begin
            presc_nx_s    = presc_r + 1'b1;
            contador_nx_s = contador_r;
        end
        if (fin_s && pendiente_r) begin
            duty_nx_s = muestra_pend_r;
        end else begin
            duty_nx_s = duty_activo_r;
        end
        pwm_nx_s = (contador_nx_s < duty_nx_s);
        fin_nx_s = (presc_nx_s == PRESC_FIN) && (contador_nx_s == CONT_FIN);
    end

    // Period timebase, active duty and the registered PWM outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_r         <= 1'b0;
            presc_r       <= {PW{1'b0}};
            contador_r    <= {BITS_PWM{1'b0}};
            duty_activo_r <= DUTY_NEUTRO;
            pwm_out       <= 1'b0;
            fin_periodo   <= 1'b0;
        end else begin
            run_r         <= 1'b1;
            presc_r       <= presc_nx_s;
            contador_r    <= contador_nx_s;
            duty_activo_r <= duty_nx_s;
            pwm_out       <= pwm_nx_s;
            fin_periodo   <= fin_nx_s;
        end
    end

    // Pending-sample buffer, saturation flags and lost-sample pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            muestra_pend_r  <= {BITS_PWM{1'b0}};
            pendiente_r     <= 1'b0;
            sat_alto        <= 1'b0;
            sat_bajo        <= 1'b0;
            muestra_perdida <= 1'b0;
        end else if (entrada.dato_valid) begin
            muestra_pend_r  <= duty_s;
            pendiente_r     <= 1'b1;
            sat_alto        <= alto_s;
            sat_bajo        <= bajo_s;
            // a sample consumed at the period end in this same cycle is not lost
            muestra_perdida <= pendiente_r && !fin_s;
        end else begin
            muestra_pend_r  <= muestra_pend_r;
            pendiente_r     <= pendiente_r && !fin_s;
            sat_alto        <= sat_alto;
            sat_bajo        <= sat_bajo;
            muestra_perdida <= 1'b0;
        end
    end
endmodule

// File: tb/tb_truncador_saturado_pwm.sv
// Directed bench for truncador_saturado_pwm: three instances (truncating, rounding, DIV=3)
// checked period by period against a scoreboard of expected high times.
module tb_truncador_saturado_pwm;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a  [3] = '{1'b0, 1'b0, 1'b0};
    logic pwm_a  [3];
    logic fin_a  [3];
    logic sa_a   [3];
    logic sb_a   [3];
    logic perd_a [3];

    truncador_saturado_pwm_if #(.CANT_BITS(13)) bus0 ();
    truncador_saturado_pwm_if #(.CANT_BITS(13)) bus1 ();
    truncador_saturado_pwm_if #(.CANT_BITS(13)) bus2 ();

    truncador_saturado_pwm #(.CANT_BITS(13), .BITS_PWM(8), .DESPL(2), .REDONDEO(0), .DIV(1)) dut0 (
        .clk(clk), .rst_n(rst_a[0]), .entrada(bus0.slave), .pwm_out(pwm_a[0]), .fin_periodo(fin_a[0]),
        .sat_alto(sa_a[0]), .sat_bajo(sb_a[0]), .muestra_perdida(perd_a[0]));
    truncador_saturado_pwm #(.CANT_BITS(13), .BITS_PWM(8), .DESPL(2), .REDONDEO(1), .DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_a[1]), .entrada(bus1.slave), .pwm_out(pwm_a[1]), .fin_periodo(fin_a[1]),
        .sat_alto(sa_a[1]), .sat_bajo(sb_a[1]), .muestra_perdida(perd_a[1]));
    truncador_saturado_pwm #(.CANT_BITS(13), .BITS_PWM(8), .DESPL(2), .REDONDEO(0), .DIV(3)) dut2 (
        .clk(clk), .rst_n(rst_a[2]), .entrada(bus2.slave), .pwm_out(pwm_a[2]), .fin_periodo(fin_a[2]),
        .sat_alto(sa_a[2]), .sat_bajo(sb_a[2]), .muestra_perdida(perd_a[2]));

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];
    int active;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic drive(input int d, input logic v, input logic signed [12:0] x);
        case (d)
            0: begin bus0.dato_valid = v; bus0.dato_infiltro = x; end
            1: begin bus1.dato_valid = v; bus1.dato_infiltro = x; end
            2: begin bus2.dato_valid = v; bus2.dato_infiltro = x; end
            default: ;
        endcase
    endtask

    function automatic logic [31:0] outs(input int d);
        return {27'd0, pwm_a[d], fin_a[d], sa_a[d], sb_a[d], perd_a[d]};
    endfunction

    // Reset for 3 cycles with a valid sample offered (must be ignored), then release
    task automatic start(input int d, input int div, input string tag);
        rst_a[d] = 1'b0;
        drive(d, 1'b1, 13'sd4095);
        repeat (3) @(negedge clk);
        chk({tag, " reset_outs"}, outs(d), 32'd0);
        rst_a[d] = 1'b1;
        drive(d, 1'b0, 13'sd0);
        @(negedge clk);
        chk({tag, " first_pwm"}, {31'd0, pwm_a[d]}, 32'd1);
        chk({tag, " first_fin"}, {31'd0, fin_a[d]}, 32'd0);
        exp_q.delete();
        active = 128 * div;
    endtask

    // One full period from its first cycle; up to two injected samples at cycle offsets i1/i2
    task automatic run_period(input int d, input int div,
                              input int i1, input logic signed [12:0] v1, input int d1,
                              input logic sa1, input logic sb1,
                              input int i2, input logic signed [12:0] v2, input int d2,
                              input int exp_perd, input string tag);
        int p;
        int hi;
        int fin_bad;
        int perd;
        int nxt;
        p = 256 * div;
        hi = 0;
        fin_bad = 0;
        perd = 0;
        nxt = active;
        for (int i = 0; i < p; i++) begin
            if (pwm_a[d] === 1'b1) hi++;
            if (fin_a[d] !== (i == p - 1)) fin_bad++;
            if (perd_a[d] === 1'b1) perd++;
            if (i1 >= 0 && i == i1 + 1) begin
                chk({tag, " sat_alto"}, {31'd0, sa_a[d]}, {31'd0, sa1});
                chk({tag, " sat_bajo"}, {31'd0, sb_a[d]}, {31'd0, sb1});
            end
            if (i == p - 1) begin
                if (exp_q.size() > 0) nxt = exp_q.pop_front();
            end
            if (i == i1) begin
                if (exp_q.size() > 0) void'(exp_q.pop_back());
                exp_q.push_back(d1 * div);
                drive(d, 1'b1, v1);
            end else if (i == i2) begin
                if (exp_q.size() > 0) void'(exp_q.pop_back());
                exp_q.push_back(d2 * div);
                drive(d, 1'b1, v2);
            end else begin
                drive(d, 1'b0, 13'sd0);
            end
            @(negedge clk);
        end
        drive(d, 1'b0, 13'sd0);
        chk({tag, " high_time"}, hi, active);
        chk({tag, " fin_periodo"}, fin_bad, 32'd0);
        chk({tag, " perdida"}, perd, exp_perd);
        active = nxt;
    endtask

    initial begin
        drive(0, 1'b0, 13'sd0);
        drive(1, 1'b0, 13'sd0);
        drive(2, 1'b0, 13'sd0);
        @(negedge clk);

        // Truncating instance, DIV=1
        start(0, 1, "d0");
        run_period(0, 1, 10, -13'sd256,  8'h40, 1'b0, 1'b0, -1, 13'sd0, 0, 0, "p1_boundary");
        run_period(0, 1,  5,  13'sd4095, 8'hFF, 1'b1, 1'b0, -1, 13'sd0, 0, 0, "p2_sat_hi");
        run_period(0, 1,  5, -13'sd4096, 8'h00, 1'b0, 1'b1, -1, 13'sd0, 0, 0, "p3_sat_lo");
        run_period(0, 1,  5,  13'sd400,  8'hE4, 1'b0, 1'b0, -1, 13'sd0, 0, 0, "p4_in_range");
        run_period(0, 1,  5,  13'sd6,    8'h81, 1'b0, 1'b0, -1, 13'sd0, 0, 0, "p5_trunc_pos");
        run_period(0, 1,  5, -13'sd6,    8'h7E, 1'b0, 1'b0, -1, 13'sd0, 0, 0, "p6_trunc_neg");
        run_period(0, 1, 20, -13'sd448,  8'h10, 1'b0, 1'b0, 100, -13'sd384, 8'h20, 1, "p7_overwrite");
        run_period(0, 1, 30,  13'sd0,    8'h80, 1'b0, 1'b0, 255, -13'sd448, 8'h10, 0, "p8_coincide");
        run_period(0, 1, -1,  13'sd0,    0,     1'b0, 1'b0, -1, 13'sd0, 0, 0, "p9");
        run_period(0, 1, -1,  13'sd0,    0,     1'b0, 1'b0, -1, 13'sd0, 0, 0, "p10");

        // Rounding instance, DIV=1
        start(1, 1, "d1");
        run_period(1, 1,  5,  13'sd6, 8'h82, 1'b0, 1'b0, -1, 13'sd0, 0, 0, "r1_round_pos");
        run_period(1, 1,  5, -13'sd6, 8'h7F, 1'b0, 1'b0, -1, 13'sd0, 0, 0, "r2_round_neg");
        run_period(1, 1, -1,  13'sd0, 0,     1'b0, 1'b0, -1, 13'sd0, 0, 0, "r3");

        // DIV=3 instance: sample pending at count 20, reset at count 50 discards it
        start(2, 3, "d2");
        for (int i = 0; i < 150; i++) begin
            if (i == 60) drive(2, 1'b1, 13'sd4095);
            else drive(2, 1'b0, 13'sd0);
            @(negedge clk);
        end
        start(2, 3, "d2_midreset");
        run_period(2, 3, -1, 13'sd0, 0, 1'b0, 1'b0, -1, 13'sd0, 0, 0, "m1");
        run_period(2, 3, -1, 13'sd0, 0, 1'b0, 1'b0, -1, 13'sd0, 0, 0, "m2_discarded");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
